alu_seq: RTL

Parametrised multi-cycle integer ALU, successor to the 8-bit combinational calculator ALU. It supports ADD, SUB, MUL and DIV, and DIV now returns both quotient and remainder. Operands enter through a valid/ready request handshake and results leave through a valid/ready response handshake. Multiply (shift-add) and divide (restoring) are iterative, one bit per cycle, so the block sits between the calculator's keypad/command front-end and its display formatter without a wide combinational multiplier/divider.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request handshake and result response handshake.
// W must match the alu_seq instance it is attached to.
interface alu_seq_if #(parameter int W = 8);
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     op;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] y;
  logic [W-1:0]   rem;
  logic           div_by_zero;
  logic           busy;

  modport master (
    output start_valid, a, b, op, res_ready,
    input  start_ready, res_valid, y, rem, div_by_zero, busy
  );

  modport slave (
    input  start_valid, a, b, op, res_ready,
    output start_ready, res_valid, y, rem, div_by_zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB/NOP, iterative shift-add MUL and
// restoring DIV (one bit per cycle), valid/ready on both request and response.
module alu_seq #(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_is_div;
  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_opnd;
  logic [W-1:0]   r_work;
  logic [2*W-1:0] r_y;
  logic [W-1:0]   r_rem;
  logic           r_dbz;
  logic           r_res_valid;
  logic           r_busy;

  logic           w_accept;
  logic [2*W-1:0] w_sum;
  logic [2*W-1:0] w_dif;
  logic [2*W-1:0] w_mul_acc;
  logic [W:0]     w_shift;
  logic           w_fit;
  logic [W-1:0]   w_sub;
  logic [W-1:0]   w_div_rem;
  logic [W-1:0]   w_div_quo;

  assign bus.start_ready = (r_state == IDLE) & rst_n;
  assign bus.res_valid   = r_res_valid;
  assign bus.busy        = r_busy;
  assign bus.y           = r_y;
  assign bus.rem         = r_rem;
  assign bus.div_by_zero = r_dbz;

  assign w_accept = bus.start_valid & bus.start_ready;
  assign w_sum    = {{W{1'b0}}, bus.a} + {{W{1'b0}}, bus.b};
  assign w_dif    = {{W{1'b0}}, bus.a} - {{W{1'b0}}, bus.b};

  // MUL: r_acc accumulates, r_opnd is the multiplicand shifting left, r_work the
  // multiplier shifting right. DIV: r_acc[W-1:0] is the partial remainder,
  // r_opnd[W-1:0] the divisor, r_work shifts dividend bits out and quotient bits in.
  assign w_mul_acc = r_work[0] ? (r_acc + r_opnd) : r_acc;
  assign w_shift   = {r_acc[W-1:0], r_work[W-1]};
  assign w_fit     = (w_shift >= {1'b0, r_opnd[W-1:0]});
  assign w_sub     = w_shift[W-1:0] - r_opnd[W-1:0];
  assign w_div_rem = w_fit ? w_sub : w_shift[W-1:0];
  assign w_div_quo = {r_work[W-2:0], w_fit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_work      <= '0;
      r_y         <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dbz       <= 1'b0;
            r_acc       <= '0;
            r_busy      <= 1'b1;
            r_is_div    <= (bus.op == OP_DIV);
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_rem       <= '0;
            case (bus.op)
              OP_ADD: r_y <= w_sum;
              OP_SUB: r_y <= w_dif;
              OP_MUL: begin
                r_opnd      <= {{W{1'b0}}, bus.a};
                r_work      <= bus.b;
                r_cnt       <= CW'(W);
                r_state     <= CALC;
                r_res_valid <= 1'b0;
              end
              OP_DIV: begin
                if (bus.b == '0) begin
                  r_y   <= '0;
                  r_dbz <= 1'b1;
                end else begin
                  r_opnd      <= {{W{1'b0}}, bus.b};
                  r_work      <= bus.a;
                  r_cnt       <= CW'(W);
                  r_state     <= CALC;
                  r_res_valid <= 1'b0;
                end
              end
              default: r_y <= '0;
            endcase
          end
        end
        CALC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_is_div) begin
            r_acc  <= {{W{1'b0}}, w_div_rem};
            r_work <= w_div_quo;
          end else begin
            r_acc  <= w_mul_acc;
            r_opnd <= r_opnd << 1;
            r_work <= r_work >> 1;
          end
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_y         <= r_is_div ? {{W{1'b0}}, w_div_quo} : w_mul_acc;
            r_rem       <= r_is_div ? w_div_rem : '0;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
